// File: rtl/rv_pkg.sv
// ============================================================================
// Module : rv_pkg
// Brief  : Shared opcode/funct3 constants and branch-resolve FSM state type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [0:0] {
        RESOLVE = 1'b0,
        FLUSH   = 1'b1
    } bru_state_t;

endpackage : rv_pkg

`default_nettype wire

// File: rtl/imm_gen_bj.sv
// ============================================================================
// Module : imm_gen_bj
// Brief  : Combinational B-type and J-type immediate extraction (sign-extended).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_bj (
    input  logic [31:0] instr_i,
    output logic [31:0] b_imm_o,
    output logic [31:0] j_imm_o
);

    assign b_imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
    assign j_imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

endmodule : imm_gen_bj

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module : branch_resolve_unit
// Brief  : Decode-stage BEQ/BNE/BLT/BGE/JAL resolver with post-redirect flush.
//          Optional perf counters (taken_cnt, flush_cnt) when BRU_PERF_CNT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import rv_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        beq,
    output logic        bneq,
    output logic        bge,
    output logic        blt,
    output logic        jump,
    output logic [31:0] imm_address,
    output logic [31:0] imm_address_jump,
    output logic        flush
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [3:0] c_flush_load = FLUSH_CYCLES[3:0];

    bru_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        beq_q, bneq_q, bge_q, blt_q, jump_q;
    logic        beq_d, bneq_d, bge_d, blt_d, jump_d;
    logic [31:0] imm_q, imm_d, immj_q, immj_d;
    logic [31:0] w_b_imm, w_j_imm;
    logic        w_eq, w_lt, w_take, w_branch, w_pulse_q;

    imm_gen_bj u_imm_gen_bj (
        .instr_i (instr),
        .b_imm_o (w_b_imm),
        .j_imm_o (w_j_imm)
    );

    assign w_eq = (rs1_data == rs2_data);
    assign w_lt = ($signed(rs1_data) < $signed(rs2_data));

    always_comb begin
        beq_d  = 1'b0;
        bneq_d = 1'b0;
        bge_d  = 1'b0;
        blt_d  = 1'b0;
        jump_d = 1'b0;
        if (instr_valid && (state_q == RESOLVE)) begin
            if (instr[6:0] == OP_BRANCH) begin
                case (instr[14:12])
                    F3_BEQ:  beq_d  = w_eq;
                    F3_BNE:  bneq_d = ~w_eq;
                    F3_BLT:  blt_d  = w_lt;
                    F3_BGE:  bge_d  = ~w_lt;
                    default: ;
                endcase
            end else if (instr[6:0] == OP_JAL) begin
                jump_d = 1'b1;
            end
        end
    end

    assign w_branch = beq_d | bneq_d | bge_d | blt_d;
    assign w_take   = w_branch | jump_d;
    assign imm_d    = w_branch ? w_b_imm : 32'd0;
    assign immj_d   = jump_d   ? w_j_imm : 32'd0;
    assign w_pulse_q = beq_q | bneq_q | bge_q | blt_q | jump_q;

    // FLUSH is entered alongside the pulse; the counter holds during the
    // pulse cycle so the squash window covers the FLUSH_CYCLES cycles after it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RESOLVE: begin
                if (w_take && (FLUSH_CYCLES != 0)) begin
                    state_d = FLUSH;
                    cnt_d   = c_flush_load;
                end
            end
            FLUSH: begin
                if (!w_pulse_q) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RESOLVE;
                    end
                end
            end
            default: state_d = RESOLVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESOLVE;
            cnt_q   <= 4'd0;
            beq_q   <= 1'b0;
            bneq_q  <= 1'b0;
            bge_q   <= 1'b0;
            blt_q   <= 1'b0;
            jump_q  <= 1'b0;
            imm_q   <= 32'd0;
            immj_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beq_q   <= beq_d;
            bneq_q  <= bneq_d;
            bge_q   <= bge_d;
            blt_q   <= blt_d;
            jump_q  <= jump_d;
            imm_q   <= imm_d;
            immj_q  <= immj_d;
        end
    end

    assign beq              = beq_q;
    assign bneq             = bneq_q;
    assign bge              = bge_q;
    assign blt              = blt_q;
    assign jump             = jump_q;
    assign imm_address      = imm_q;
    assign imm_address_jump = immj_q;
    assign flush            = (state_q == FLUSH) && !w_pulse_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] taken_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            taken_cnt_q <= taken_cnt_q + 32'(w_take);
            flush_cnt_q <= flush_cnt_q + 32'(flush);
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule : branch_resolve_unit

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module : tb_branch_resolve_unit
// Brief  : Directed self-checking bench for branch_resolve_unit (FLUSH_CYCLES=2).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

    localparam logic [31:0] I_BEQ  = 32'h0020_8863;  // beq  x1,x2,+16
    localparam logic [31:0] I_BNE  = 32'h0020_9863;
    localparam logic [31:0] I_BLT  = 32'h0020_C863;
    localparam logic [31:0] I_BGE  = 32'h0020_D863;
    localparam logic [31:0] I_F3_2 = 32'h0020_A863;  // funct3 010: no-op
    localparam logic [31:0] I_JAL  = 32'hFFDF_F06F;  // jal x0,-4

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr, rs1_data, rs2_data;
    logic        beq, bneq, bge, blt, jump, flush;
    logic [31:0] imm_address, imm_address_jump;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] taken_cnt, flush_cnt;
    logic        p_reset, p_valid;
    logic        p_beq, p_bneq, p_bge, p_blt, p_jump, p_flush;
    logic [31:0] p_imm, p_immj, p_taken_cnt, p_flush_cnt;
`endif

    branch_resolve_unit #(.FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .beq              (beq),
        .bneq             (bneq),
        .bge              (bge),
        .blt              (blt),
        .jump             (jump),
        .imm_address      (imm_address),
        .imm_address_jump (imm_address_jump),
        .flush            (flush)
`ifdef BRU_PERF_CNT_EN
        ,
        .taken_cnt        (taken_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

`ifdef BRU_PERF_CNT_EN
    branch_resolve_unit #(.FLUSH_CYCLES(3)) u_perf (
        .clk              (clk),
        .reset            (p_reset),
        .instr_valid      (p_valid),
        .instr            (instr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .beq              (p_beq),
        .bneq             (p_bneq),
        .bge              (p_bge),
        .blt              (p_blt),
        .jump             (p_jump),
        .imm_address      (p_imm),
        .imm_address_jump (p_immj),
        .flush            (p_flush),
        .taken_cnt        (p_taken_cnt),
        .flush_cnt        (p_flush_cnt)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // pulses ordered {beq, bneq, bge, blt, jump}
    task automatic expect_out(input string tag, input logic [4:0] pulses,
                              input logic [31:0] ia, input logic [31:0] ij,
                              input logic fl);
        chk({tag, ".pulses"}, {27'd0, beq, bneq, bge, blt, jump}, {27'd0, pulses});
        chk({tag, ".imm"},    imm_address,      ia);
        chk({tag, ".immj"},   imm_address_jump, ij);
        chk({tag, ".flush"},  {31'd0, flush},   {31'd0, fl});
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        instr_valid = v;
        instr       = ins;
        rs1_data    = a;
        rs2_data    = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
`ifdef BRU_PERF_CNT_EN
        p_reset = 1'b1;
        p_valid = 1'b0;
`endif
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        expect_out("reset", 5'b00000, 32'd0, 32'd0, 1'b0);
        reset = 1'b0;

        // Taken BEQ: one-cycle pulse, then two flush cycles
        drive(1'b1, I_BEQ, 32'd5, 32'd5);
        step();
        expect_out("beq_taken", 5'b10000, 32'h10, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        expect_out("beq_flush1", 5'b00000, 32'd0, 32'd0, 1'b1);
        step();
        expect_out("beq_flush2", 5'b00000, 32'd0, 32'd0, 1'b1);
        step();
        expect_out("beq_done", 5'b00000, 32'd0, 32'd0, 1'b0);

        // Not-taken BEQ and funct3 no-op
        drive(1'b1, I_BEQ, 32'd5, 32'd6);
        step();
        expect_out("beq_nt", 5'b00000, 32'd0, 32'd0, 1'b0);
        drive(1'b1, I_F3_2, 32'd5, 32'd5);
        step();
        expect_out("f3_noop", 5'b00000, 32'd0, 32'd0, 1'b0);

        // Taken BNE
        drive(1'b1, I_BNE, 32'd5, 32'd6);
        step();
        expect_out("bne_taken", 5'b01000, 32'h10, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        step();
        expect_out("bne_done", 5'b00000, 32'd0, 32'd0, 1'b0);

        // Signed boundaries
        drive(1'b1, I_BLT, 32'h8000_0000, 32'h7FFF_FFFF);
        step();
        expect_out("blt_signed", 5'b00010, 32'h10, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        step();
        drive(1'b1, I_BGE, 32'hFFFF_FFFF, 32'h0);
        step();
        expect_out("bge_signed_nt", 5'b00000, 32'd0, 32'd0, 1'b0);
        drive(1'b1, I_BGE, 32'h0, 32'hFFFF_FFFF);
        step();
        expect_out("bge_signed_t", 5'b00100, 32'h10, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        step();

        // JAL, then a taken BEQ in the shadow is discarded
        drive(1'b1, I_JAL, 32'd0, 32'd0);
        step();
        expect_out("jal", 5'b00001, 32'd0, 32'hFFFF_FFFC, 1'b0);
        drive(1'b1, I_BEQ, 32'd7, 32'd7);
        step();
        expect_out("jal_shadow1", 5'b00000, 32'd0, 32'd0, 1'b1);
        step();
        expect_out("jal_shadow2", 5'b00000, 32'd0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        expect_out("jal_done", 5'b00000, 32'd0, 32'd0, 1'b0);

        // Reset on the first flush cycle abandons the flush
        drive(1'b1, I_BEQ, 32'd1, 32'd1);
        step();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        expect_out("rst_pre", 5'b00000, 32'd0, 32'd0, 1'b1);
        reset = 1'b1;
        step();
        expect_out("rst_mid_flush", 5'b00000, 32'd0, 32'd0, 1'b0);
        reset = 1'b0;
        drive(1'b1, I_JAL, 32'd0, 32'd0);
        step();
        expect_out("rst_accept", 5'b00001, 32'd0, 32'hFFFF_FFFC, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        step();

        // Reset wins over a simultaneous taken instruction
        reset = 1'b1;
        drive(1'b1, I_BEQ, 32'd3, 32'd3);
        step();
        expect_out("rst_vs_taken", 5'b00000, 32'd0, 32'd0, 1'b0);
        reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        expect_out("post_rst_idle", 5'b00000, 32'd0, 32'd0, 1'b0);

`ifdef BRU_PERF_CNT_EN
        p_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, I_BEQ, 32'd9, 32'd9);
            p_valid = 1'b1;
            step();
            p_valid = 1'b0;
            for (int j = 0; j < 4; j++) step();
        end
        chk("perf_taken_cnt", p_taken_cnt, 32'd3);
        chk("perf_flush_cnt", p_flush_cnt, 32'd9);
        chk("main_taken_cnt", taken_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_resolve_unit

`default_nettype wire
